// File: rtl/rv32i_types.sv
// Shared types for the branch flush controller and its neighbours.
// The controller's FSM state encoding and the redirect bundle driven to the frontend live here.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HEAD = 2'd1,
    FLUSH     = 2'd2,
    DRAIN     = 2'd3
  } flush_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } redirect_t;

endpackage

// File: rtl/rob_age_cmp.sv
// Modular ROB age comparison: a_older is set when entry a is strictly older than entry b,
// measuring both as distance from the current head. Also used by the load/store queue.
module rob_age_cmp #(
  parameter int ROB_IDX_W = 5
) (
  input  logic [ROB_IDX_W-1:0] a,
  input  logic [ROB_IDX_W-1:0] b,
  input  logic [ROB_IDX_W-1:0] head,
  output logic                 a_older
);

  logic [ROB_IDX_W-1:0] a_age;
  logic [ROB_IDX_W-1:0] b_age;

  // Subtraction wraps at the ROB depth, giving the distance from head.
  assign a_age   = a - head;
  assign b_age   = b - head;
  assign a_older = (a_age < b_age);

endmodule

// File: rtl/branch_flush_ctrl.sv
// Holds the oldest mispredicted branch until it commits, then issues a one-cycle flush and
// redirect and stalls the frontend while memory drains. Define BRANCH_FLUSH_PERF_EN for the perf counter.
module branch_flush_ctrl
  import rv32i_types::*;
#(
  parameter int ROB_IDX_W    = 5,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 resolve_valid,
  input  logic                 resolve_mispredict,
  input  logic [ROB_IDX_W-1:0] resolve_rob_idx,
  input  logic [31:0]          resolve_target,
  input  logic [ROB_IDX_W-1:0] rob_head_idx,
  input  logic                 rob_commit,
  input  logic                 dmem_outstanding,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 stall_frontend,
  output logic                 busy,
  output logic [31:0]          perf_mispredict_cnt
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  flush_state_t         state_q, state_d;
  logic [ROB_IDX_W-1:0] pend_idx_q, pend_idx_d;
  logic [31:0]          pend_target_q, pend_target_d;
  logic [3:0]           drain_cnt_q, drain_cnt_d;
  logic                 flush_q, flush_d;
  redirect_t            redirect_q, redirect_d;
  logic                 stall_q, stall_d;
  logic                 busy_q, busy_d;
  logic                 mispredict;
  logic                 resolve_older;

  assign mispredict = resolve_valid && resolve_mispredict;

  rob_age_cmp #(
    .ROB_IDX_W(ROB_IDX_W)
  ) u_age_cmp (
    .a      (resolve_rob_idx),
    .b      (pend_idx_q),
    .head   (rob_head_idx),
    .a_older(resolve_older)
  );

  always_comb begin
    state_d       = state_q;
    pend_idx_d    = pend_idx_q;
    pend_target_d = pend_target_q;
    drain_cnt_d   = drain_cnt_q;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          pend_idx_d    = resolve_rob_idx;
          pend_target_d = resolve_target;
          state_d       = WAIT_HEAD;
        end
      end
      WAIT_HEAD: begin
        // A strictly older mispredict wins even over the pending branch committing.
        if (mispredict && resolve_older) begin
          pend_idx_d    = resolve_rob_idx;
          pend_target_d = resolve_target;
        end else if (rob_commit && (rob_head_idx == pend_idx_q)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        drain_cnt_d = 4'd0;
        state_d     = DRAIN;
      end
      DRAIN: begin
        if ((drain_cnt_q >= DRAIN_LAST) && !dmem_outstanding) begin
          state_d = IDLE;
        end else if (drain_cnt_q != 4'hF) begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    flush_d          = (state_d == FLUSH);
    redirect_d.valid = (state_d == FLUSH);
    redirect_d.pc    = (state_d == FLUSH) ? pend_target_d : 32'd0;
    stall_d          = (state_d == FLUSH) || (state_d == DRAIN);
    busy_d           = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pend_idx_q    <= '0;
      pend_target_q <= 32'd0;
      drain_cnt_q   <= 4'd0;
      flush_q       <= 1'b0;
      redirect_q    <= '0;
      stall_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_idx_q    <= pend_idx_d;
      pend_target_q <= pend_target_d;
      drain_cnt_q   <= drain_cnt_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      stall_q       <= stall_d;
      busy_q        <= busy_d;
    end
  end

  assign flush          = flush_q;
  assign redirect_valid = redirect_q.valid;
  assign redirect_pc    = redirect_q.pc;
  assign stall_frontend = stall_q;
  assign busy           = busy_q;

`ifdef BRANCH_FLUSH_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  // Counts FLUSH cycles, saturating at all-ones.
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if ((state_q == FLUSH) && (perf_cnt_q != 32'hFFFF_FFFF)) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_q <= 32'd0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_mispredict_cnt = perf_cnt_q;
`else
  assign perf_mispredict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Directed, table-driven bench for branch_flush_ctrl (ROB_IDX_W=5, DRAIN_CYCLES=2),
// with hand-written sequences for the drain hold, reset mid-DRAIN and perf counter.
module tb_branch_flush_ctrl;

`ifdef BRANCH_FLUSH_PERF_EN
  localparam logic [31:0] PERF_EXP = 32'd1;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  logic        clk;
  logic        rst;
  logic        resolve_valid;
  logic        resolve_mispredict;
  logic [4:0]  resolve_rob_idx;
  logic [31:0] resolve_target;
  logic [4:0]  rob_head_idx;
  logic        rob_commit;
  logic        dmem_outstanding;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_frontend;
  logic        busy;
  logic [31:0] perf_mispredict_cnt;

  int checks;
  int failures;

  branch_flush_ctrl #(
    .ROB_IDX_W   (5),
    .DRAIN_CYCLES(2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .resolve_valid      (resolve_valid),
    .resolve_mispredict (resolve_mispredict),
    .resolve_rob_idx    (resolve_rob_idx),
    .resolve_target     (resolve_target),
    .rob_head_idx       (rob_head_idx),
    .rob_commit         (rob_commit),
    .dmem_outstanding   (dmem_outstanding),
    .flush              (flush),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .stall_frontend     (stall_frontend),
    .busy               (busy),
    .perf_mispredict_cnt(perf_mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic        rm;
    logic [4:0]  idx;
    logic [31:0] tgt;
    logic [4:0]  head;
    logic        commit;
    logic        dmem;
    logic        e_flush;
    logic        e_rvld;
    logic [31:0] e_pc;
    logic        e_stall;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic r, logic v, logic m, logic [4:0] i, logic [31:0] t,
                              logic [4:0] h, logic c, logic d, logic ef, logic erv,
                              logic [31:0] epc, logic est, logic eb);
    vec_t x;
    x.rst = r; x.rv = v; x.rm = m; x.idx = i; x.tgt = t; x.head = h; x.commit = c;
    x.dmem = d; x.e_flush = ef; x.e_rvld = erv; x.e_pc = epc; x.e_stall = est; x.e_busy = eb;
    vq.push_back(x);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply(logic r, logic v, logic m, logic [4:0] i, logic [31:0] t,
                       logic [4:0] h, logic c, logic d);
    @(negedge clk);
    rst = r; resolve_valid = v; resolve_mispredict = m; resolve_rob_idx = i;
    resolve_target = t; rob_head_idx = h; rob_commit = c; dmem_outstanding = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(string tag, logic ef, logic erv, logic [31:0] epc, logic est, logic eb);
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, ef});
    chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, erv});
    chk({tag, ".redirect_pc"}, redirect_pc, epc);
    chk({tag, ".stall"}, {31'd0, stall_frontend}, {31'd0, est});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; resolve_valid = 1'b0; resolve_mispredict = 1'b0; resolve_rob_idx = '0;
    resolve_target = '0; rob_head_idx = '0; rob_commit = 1'b0; dmem_outstanding = 1'b0;

    // Reset, correctly predicted resolve ignored, single mispredict idx 3
    add(1,0,0,0,0,0,0,0,          0,0,0,0,0);
    add(0,1,0,5,32'h9999,0,0,0,   0,0,0,0,0);
    add(0,1,1,3,32'h1000,0,0,0,   0,0,0,0,1);
    add(0,0,0,0,0,1,1,0,          0,0,0,0,1);
    add(0,0,0,0,0,3,0,0,          0,0,0,0,1);
    add(0,0,0,0,0,3,1,0,          1,1,32'h1000,1,1);
    add(0,1,1,0,32'hDEAD,4,0,0,   0,0,0,1,1);
    add(0,1,1,2,32'hBEEF,4,0,0,   0,0,0,1,1);
    add(0,0,0,0,0,4,0,0,          0,0,0,0,0);
    // Older replaces younger: head 2, pending 7, new 4
    add(0,1,1,7,32'h2000,2,0,0,   0,0,0,0,1);
    add(0,1,1,4,32'h3000,2,0,0,   0,0,0,0,1);
    add(0,0,0,0,0,7,1,0,          0,0,0,0,1);
    add(0,0,0,0,0,4,1,0,          1,1,32'h3000,1,1);
    add(0,0,0,0,0,5,0,0,          0,0,0,1,1);
    add(0,0,0,0,0,5,0,0,          0,0,0,1,1);
    add(0,0,0,0,0,5,0,0,          0,0,0,0,0);
    // Wrap-around: head 30, pending 1, 31 replaces, equal and younger do not
    add(0,1,1,1,32'h4000,30,0,0,  0,0,0,0,1);
    add(0,1,1,31,32'h5000,30,0,0, 0,0,0,0,1);
    add(0,1,1,31,32'h6000,30,0,0, 0,0,0,0,1);
    add(0,1,1,0,32'h7000,30,0,0,  0,0,0,0,1);
    add(0,0,0,0,0,31,1,0,         1,1,32'h5000,1,1);
    add(0,0,0,0,0,0,0,0,          0,0,0,1,1);
    add(0,0,0,0,0,0,0,0,          0,0,0,1,1);
    add(0,0,0,0,0,0,0,0,          0,0,0,0,0);
    // Reset mid-WAIT_HEAD, and reset overriding a same-cycle mispredict
    add(0,1,1,2,32'h8000,0,0,0,   0,0,0,0,1);
    add(1,0,0,0,0,2,1,0,          0,0,0,0,0);
    add(0,0,0,0,0,2,1,0,          0,0,0,0,0);
    add(1,1,1,1,32'hA000,0,0,0,   0,0,0,0,0);
    add(0,0,0,0,0,1,1,0,          0,0,0,0,0);

    for (int k = 0; k < vq.size(); k++) begin
      apply(vq[k].rst, vq[k].rv, vq[k].rm, vq[k].idx, vq[k].tgt, vq[k].head, vq[k].commit,
            vq[k].dmem);
      chk_out($sformatf("row%0d", k), vq[k].e_flush, vq[k].e_rvld, vq[k].e_pc,
              vq[k].e_stall, vq[k].e_busy);
    end
    chk("perf_after_reset", perf_mispredict_cnt, 32'd0);

    // Drain hold: dmem_outstanding high through 5 DRAIN cycles, then drop
    apply(0,1,1,3,32'hC000,0,0,0);
    chk_out("hold.wait", 0,0,0,0,1);
    apply(0,0,0,0,0,3,1,0);
    chk_out("hold.flush", 1,1,32'hC000,1,1);
    for (int k = 0; k < 6; k++) begin
      apply(0,0,0,0,0,4,0,1);
      chk_out($sformatf("hold.drain%0d", k), 0,0,0,1,1);
    end
    apply(0,0,0,0,0,4,0,0);
    chk_out("hold.release", 0,0,0,0,0);
    chk("perf_one_flush", perf_mispredict_cnt, PERF_EXP);

    // Reset mid-DRAIN
    apply(0,1,1,6,32'hD000,0,0,0);
    chk_out("rstdrain.wait", 0,0,0,0,1);
    apply(0,0,0,0,0,6,1,0);
    chk_out("rstdrain.flush", 1,1,32'hD000,1,1);
    apply(0,0,0,0,0,7,0,1);
    chk_out("rstdrain.drain", 0,0,0,1,1);
    apply(1,0,0,0,0,7,0,1);
    chk_out("rstdrain.rst", 0,0,0,0,0);
    chk("perf_rst_drain", perf_mispredict_cnt, 32'd0);
    apply(0,0,0,0,0,7,0,1);
    chk_out("rstdrain.idle", 0,0,0,0,0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
